fp_accumulate_top: RTL
======================

# fp_accumulate_top

Single-precision (IEEE 754 binary32) accumulator that sits directly downstream of `multiply_top` in the neural-network datapath. It consumes a stream of products, sums them into a running fp32 accumulator with a fixed 4-cycle-per-term FSM, and presents the finished dot-product sum when the term flagged `last_i` has been added. The accumulator then clears for the next neuron.

## Interface
- `COUNT_W`, default 16: width of the accepted-term counter.

- `clk_i` input 1: sole clock; all state updates on the rising edge.
- `reset_i` input 1: synchronous, active-high reset.
- `product_i` input 32: fp32 term, normally `product_o` of the multiplier.
- `product_valid_i` input 1: `product_i` and `last_i` are valid.
- `last_i` input 1: this term closes the current sum.
- `product_ready_o` output 1: accumulator accepts a term this cycle.
- `sum_o` output 32: finished fp32 sum; stable while `sum_valid_o` is high.
- `sum_valid_o` output 1: `sum_o` is valid.
- `sum_ready_i` input 1: consumer takes `sum_o`.
- `term_count_o` output COUNT_W: terms accepted in the current sum; saturates at all-ones.

## Operation
- States: IDLE, ALIGN, ADD, NORM, OUT.
  - IDLE: `product_ready_o`=1. On `product_valid_i`&`product_ready_o`, latch the term and `last_i`, increment `term_count_o`, and go to ALIGN.
  - ALIGN: unpack both operands with the hidden 1, giving 24-bit mantissas. Shift the smaller-magnitude mantissa right by the exponent difference. Shifted-out bits are discarded (truncation). A difference of 25 or more makes the smaller operand contribute 0. Go to ADD.
  - ADD: 25-bit add on equal signs, or larger-minus-smaller on unequal signs. Result sign is the sign of the larger magnitude. Go to NORM.
  - NORM:
    - Carry out: shift right 1, exponent +1.
    - Otherwise: single-cycle leading-zero count, shift left, exponent −count.
    - Write the accumulator. Go to OUT if the latched `last_i` is set, else IDLE.
  - OUT: `sum_valid_o`=1 and `product_ready_o`=0. On `sum_ready_i`, clear the accumulator to +0 and `term_count_o` to 0, then go to IDLE.
- Special values:
  - Exponent field 0 (zero or denormal) is treated as ±0: flush-to-zero.
  - A sum of exactly 0, including from cancellation, becomes +0 (0x00000000).
  - Biased exponent ≥255 after NORM becomes ±infinity (0x7F800000 with sign).
  - Biased exponent ≤0 becomes +0.
  - Any input with exponent 255 sets a sticky NaN flag. While the flag is set the accumulator reads 0x7FC00000. The flag clears with the accumulator.
- Rounding: round-toward-zero by truncation. Exact sums (e.g. integers < 2^24) are bit-exact.
- `product_i` is ignored outside IDLE. The upstream stage holds the term until the handshake.

## Timing
- Reset values:
  - State IDLE, accumulator 0x00000000, NaN flag 0.
  - `sum_o`=0, `sum_valid_o`=0, `term_count_o`=0, `product_ready_o`=1 in the cycle after reset.
- Throughput: one term per 4 cycles (IDLE→ALIGN→ADD→NORM). `product_ready_o` is low for the 3 cycles after each handshake.
- Latency: `sum_valid_o` rises 3 clock edges after the handshake edge of the `last_i` term.
  - `sum_o` equals the accumulator from that cycle on.
  - `sum_o` is held stable until the `sum_ready_i` handshake.
  - `sum_valid_o` falls on the edge following the handshake.
- Backpressure: while in OUT with `sum_ready_i`=0, all outputs hold and no terms are accepted.
- Simultaneous events:
  - `reset_i` has priority over every handshake.
  - `sum_ready_i` outside OUT is ignored.
- Reset mid-operation (any state) aborts the sum. The partial accumulator and count are discarded, and the block returns to its reset values on the next edge.
- Term counter: saturates; no wrap. The sum itself is unaffected by saturation.

## Test plan
- Terms 0x3F800000, 0x40000000, 0x40800000 (last) → `sum_o`=0x40E00000 (7.0) and `term_count_o`=3. `sum_valid_o` rises exactly 3 edges after the last handshake.
- Multiplier outputs 0x41200000 then 0xC1A80000 (last) → 0xC1300000 (−11.0). A single term 0x40100000 with `last_i` → 0x40100000 unchanged.
- Cancellation: 0x40200000 + 0xC0200000 → 0x00000000. Denormal 0x00000001 + 0x3F800000 → 0x3F800000.
- Overflow: 0x7F000000 + 0x7F000000 → 0x7F800000. Any term 0x7FC00000 → 0x7FC00000 regardless of the other terms.
- Backpressure: hold `sum_ready_i`=0 for 5 cycles in OUT.
  - `sum_o` and `sum_valid_o` stay constant and `product_ready_o`=0 throughout.
  - After the handshake the next sum starts from +0.
  - `product_valid_i` held high during the NORM cycles is not accepted early.
- Reset in ADD during a second term → next cycle `sum_valid_o`=0, `term_count_o`=0, `product_ready_o`=1. A fresh single term 0x3FC00000 (last) yields 0x3FC00000.

Source files
------------

// File: rtl/fp_accumulate_top.sv
// fp_accumulate_top: fp32 running-sum accumulator with a 4-cycle-per-term FSM.
// Flush-to-zero inputs, truncating (round-toward-zero) adds, sticky NaN,
// saturating term counter, valid/ready handshakes on both sides.
module fp_accumulate_top #(
  parameter int COUNT_W = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [31:0]        product_i,
  input  logic               product_valid_i,
  input  logic               last_i,
  output logic               product_ready_o,
  output logic [31:0]        sum_o,
  output logic               sum_valid_o,
  input  logic               sum_ready_i,
  output logic [COUNT_W-1:0] term_count_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Leading-zero count of a 24-bit mantissa; 24 when the input is zero.
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd24;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(23 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  state_t             state_r;
  logic [31:0]        term_r;
  logic               last_r;
  logic [31:0]        acc_r;
  logic               nan_r;
  logic [COUNT_W-1:0] count_r;
  logic               ready_r;
  logic               valid_r;

  // Aligned operands (ALIGN -> ADD) and raw sum (ADD -> NORM).
  logic               big_sign_r;
  logic               sub_r;
  logic [7:0]         big_exp_r;
  logic [23:0]        big_mant_r;
  logic [23:0]        small_mant_r;
  logic [24:0]        sum_r;

  // Alignment datapath signals.
  logic [7:0]  a_exp_s, b_exp_s, diff_s;
  logic [23:0] a_mant_s, b_mant_s;
  logic        a_ge_b_s;
  logic [7:0]  al_big_exp_s;
  logic [23:0] al_big_mant_s, al_small_mant_s, al_shifted_s;
  logic        al_big_sign_s;
  logic [7:0]  al_small_exp_s;

  // Normalisation datapath signals.
  logic [4:0]         lz_s;
  logic [23:0]        norm_mant_s;
  logic signed [9:0]  norm_exp_s;
  logic [31:0]        norm_result_s;

  // Unpack accumulator and term with flush-to-zero, pick the larger magnitude, shift the smaller.
  always_comb begin
    a_exp_s  = acc_r[30:23];
    b_exp_s  = term_r[30:23];
    a_mant_s = (a_exp_s == 8'd0) ? 24'd0 : {1'b1, acc_r[22:0]};
    b_mant_s = (b_exp_s == 8'd0) ? 24'd0 : {1'b1, term_r[22:0]};
    a_ge_b_s = ({a_exp_s, a_mant_s} >= {b_exp_s, b_mant_s});
    if (a_ge_b_s) begin
      al_big_exp_s    = a_exp_s;
      al_big_mant_s   = a_mant_s;
      al_big_sign_s   = acc_r[31];
      al_small_exp_s  = b_exp_s;
      al_small_mant_s = b_mant_s;
    end else begin
      al_big_exp_s    = b_exp_s;
      al_big_mant_s   = b_mant_s;
      al_big_sign_s   = term_r[31];
      al_small_exp_s  = a_exp_s;
      al_small_mant_s = a_mant_s;
    end
    diff_s = al_big_exp_s - al_small_exp_s;
    if (diff_s >= 8'd25) begin
      al_shifted_s = 24'd0;
    end else begin
      al_shifted_s = al_small_mant_s >> diff_s;
    end
  end

  // Renormalise the raw sum, then apply zero / overflow / underflow / NaN rules.
  always_comb begin
    lz_s = lzc24(sum_r[23:0]);
    if (sum_r[24]) begin
      norm_mant_s = sum_r[24:1];
      norm_exp_s  = $signed({2'b00, big_exp_r}) + 10'sd1;
    end else begin
      norm_mant_s = sum_r[23:0] << lz_s;
      norm_exp_s  = $signed({2'b00, big_exp_r}) - $signed({5'b00000, lz_s});
    end
    if (nan_r) begin
      norm_result_s = QNAN;
    end else if (sum_r == 25'd0) begin
      norm_result_s = 32'h0000_0000;
    end else if (norm_exp_s >= 10'sd255) begin
      norm_result_s = {big_sign_r, 8'hFF, 23'd0};
    end else if (norm_exp_s <= 10'sd0) begin
      norm_result_s = 32'h0000_0000;
    end else begin
      norm_result_s = {big_sign_r, norm_exp_s[7:0], norm_mant_s[22:0]};
    end
  end

  // Main FSM: term handshake, align/add/normalise pipeline steps, result handshake.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= S_IDLE;
      term_r       <= 32'd0;
      last_r       <= 1'b0;
      acc_r        <= 32'd0;
      nan_r        <= 1'b0;
      count_r      <= '0;
      ready_r      <= 1'b1;
      valid_r      <= 1'b0;
      big_sign_r   <= 1'b0;
      sub_r        <= 1'b0;
      big_exp_r    <= 8'd0;
      big_mant_r   <= 24'd0;
      small_mant_r <= 24'd0;
      sum_r        <= 25'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (product_valid_i) begin
            term_r  <= product_i;
            last_r  <= last_i;
            ready_r <= 1'b0;
            if (product_i[30:23] == 8'hFF) begin
              nan_r <= 1'b1;
            end else begin
              nan_r <= nan_r;
            end
            if (count_r != {COUNT_W{1'b1}}) begin
              count_r <= count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
            end else begin
              count_r <= count_r;
            end
            state_r <= S_ALIGN;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ALIGN: begin
          big_sign_r   <= al_big_sign_s;
          sub_r        <= acc_r[31] ^ term_r[31];
          big_exp_r    <= al_big_exp_s;
          big_mant_r   <= al_big_mant_s;
          small_mant_r <= al_shifted_s;
          state_r      <= S_ADD;
        end
        S_ADD: begin
          if (sub_r) begin
            sum_r <= {1'b0, big_mant_r} - {1'b0, small_mant_r};
          end else begin
            sum_r <= {1'b0, big_mant_r} + {1'b0, small_mant_r};
          end
          state_r <= S_NORM;
        end
        S_NORM: begin
          acc_r <= norm_result_s;
          if (last_r) begin
            valid_r <= 1'b1;
            state_r <= S_OUT;
          end else begin
            ready_r <= 1'b1;
            state_r <= S_IDLE;
          end
        end
        S_OUT: begin
          if (sum_ready_i) begin
            acc_r   <= 32'd0;
            nan_r   <= 1'b0;
            count_r <= '0;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            state_r <= S_IDLE;
          end else begin
            state_r <= S_OUT;
          end
        end
        default: begin
          state_r <= S_IDLE;
          ready_r <= 1'b1;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign product_ready_o = ready_r;
  assign sum_o           = acc_r;
  assign sum_valid_o     = valid_r;
  assign term_count_o    = count_r;

endmodule
